// File: rtl/serv_dbus_if.sv
// SERV data-bus bridge: core load/store request -> single Wishbone classic cycle, 3+ cycles per access.
// Core request held until o_ack/o_err; bus waits on i_wb_ack (bounded by TO_CYCLES when SERV_DBUS_TIMEOUT_EN).
module serv_dbus_if #(
  parameter int unsigned TO_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_adr,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_wdat,
  output logic        o_load,
  output logic [31:0] o_rdat,
  output logic        o_ack,
  output logic        o_err,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack
);

  if (TO_CYCLES < 1 || TO_CYCLES > 65535) begin : g_bad_to_cycles
    $error("serv_dbus_if: TO_CYCLES must be in 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [29:0] adr_q, adr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] dat_q, dat_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic        misalign;
  logic [3:0]  sel_new;

`ifdef SERV_DBUS_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TO_CYCLES - 1);
  logic [15:0] to_cnt_q, to_cnt_d;
`endif

  assign misalign = ((i_size == 2'b01) && i_adr[0]) ||
                    (i_size[1] && (i_adr[1:0] != 2'b00));

  always_comb begin
    sel_new = 4'b1111;
    case (i_size)
      2'b00:   sel_new = 4'b0001 << i_adr[1:0];
      2'b01:   sel_new = i_adr[1] ? 4'b1100 : 4'b0011;
      default: sel_new = 4'b1111;
    endcase
  end

  // err_q also masks the IDLE request check so a still-held request is not re-flagged.
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    we_d    = we_q;
    err_d   = 1'b0;
`ifdef SERV_DBUS_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_req && !err_q) begin
          if (misalign) begin
            err_d = 1'b1;
          end else begin
            state_d = BUS;
            adr_d   = i_adr[31:2];
            sel_d   = sel_new;
            dat_d   = i_wdat;
            we_d    = i_we;
`ifdef SERV_DBUS_TIMEOUT_EN
            to_cnt_d = 16'd0;
`endif
          end
        end
      end
      BUS: begin
        if (i_wb_ack) begin
          state_d = ACK;
`ifdef SERV_DBUS_TIMEOUT_EN
        end else if (to_cnt_q == TO_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
`endif
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      adr_q   <= '0;
      sel_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef SERV_DBUS_TIMEOUT_EN
      to_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      err_q   <= err_d;
`ifdef SERV_DBUS_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
`endif
    end
  end

  assign o_wb_cyc = (state_q == BUS);
  assign o_wb_adr = {adr_q, 2'b00};
  assign o_wb_dat = dat_q;
  assign o_wb_sel = sel_q;
  assign o_wb_we  = we_q;
  assign o_ack    = (state_q == ACK);
  assign o_err    = err_q;
  assign o_load   = o_wb_cyc && i_wb_ack && !we_q;
  assign o_rdat   = o_load ? i_wb_rdt : 32'h0;

endmodule

// File: tb/tb_serv_dbus_if.sv
// Bench for serv_dbus_if: directed table, corner sequences and random transactions vs. a rule-level model.
module tb_serv_dbus_if;

  localparam int TO = 4;
`ifdef SERV_DBUS_TIMEOUT_EN
  localparam int MAXW = TO - 1;
`else
  localparam int MAXW = 6;
`endif

  logic        i_clk, i_rst, i_req, i_we;
  logic [31:0] i_adr, i_wdat, i_wb_rdt;
  logic [1:0]  i_size;
  logic        i_wb_ack;
  logic        o_load, o_ack, o_err, o_wb_we, o_wb_cyc;
  logic [31:0] o_rdat, o_wb_adr, o_wb_dat;
  logic [3:0]  o_wb_sel;

  serv_dbus_if #(.TO_CYCLES(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_we(i_we), .i_adr(i_adr),
    .i_size(i_size), .i_wdat(i_wdat), .o_load(o_load), .o_rdat(o_rdat),
    .o_ack(o_ack), .o_err(o_err), .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat),
    .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we), .o_wb_cyc(o_wb_cyc),
    .i_wb_rdt(i_wb_rdt), .i_wb_ack(i_wb_ack)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [1:0]  size;
    logic [31:0] wdat;
    logic [31:0] rdt;
    int          waits;
    logic        exp_err;
    logic [3:0]  exp_sel;
    logic [31:0] exp_adr;
  } vec_t;

  typedef struct {
    int          err_n, ack_n, cyc_n, load_n, unstable, extra, leak, latency;
    logic [31:0] rdat, adr, dat;
    logic [3:0]  sel;
    logic        we;
    logic        hung;
  } obs_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after two idle trailing cycles.
  task automatic txn(input vec_t v, output obs_t o);
    int  bus_n;
    logic done;
    o = '{default: 0};
    o.hung = 1'b1;
    bus_n = 0;
    done = 1'b0;
    i_req = 1'b1; i_we = v.we; i_adr = v.adr; i_size = v.size; i_wdat = v.wdat;
    for (int c = 0; c < 200; c++) begin
      if (o_wb_cyc) i_wb_ack = (bus_n == v.waits);
      else          i_wb_ack = 1'($urandom_range(0, 1));
      i_wb_rdt = (o_wb_cyc && i_wb_ack) ? v.rdt : $urandom;
      #3;
      if (o_wb_cyc) begin
        if (bus_n == 0) begin
          o.adr = o_wb_adr; o.sel = o_wb_sel; o.dat = o_wb_dat; o.we = o_wb_we;
        end else if (o_wb_adr !== o.adr || o_wb_sel !== o.sel || o_wb_dat !== o.dat || o_wb_we !== o.we) begin
          o.unstable++;
        end
        bus_n++;
        o.cyc_n++;
      end
      if (o_load) begin o.load_n++; o.rdat = o_rdat; end
      else if (o_rdat !== 32'h0) o.leak++;
      if (o_ack) begin o.ack_n++; o.latency = c; done = 1'b1; end
      if (o_err) begin o.err_n++; o.latency = c; done = 1'b1; end
      @(posedge i_clk); #1;
      if (done) begin o.hung = 1'b0; break; end
    end
    i_req = 1'b0;
    for (int t = 0; t < 2; t++) begin
      i_wb_ack = 1'($urandom_range(0, 1));
      i_wb_rdt = $urandom;
      #3;
      if (o_ack || o_err || o_wb_cyc || o_load) o.extra++;
      @(posedge i_clk); #1;
    end
    i_wb_ack = 1'b0;
  endtask

  // Reference rules: alignment, lane select, zero-wait latency of 2 plus wait states.
  task automatic check_txn(input string nm, input vec_t v, input obs_t o);
    logic        mis;
    logic [3:0]  sel;
    logic [31:0] a;
    a = v.adr;
    mis = (v.size == 2'd1 && a % 2 != 0) || (v.size >= 2'd2 && a % 4 != 0);
    if (v.size == 2'd0)      sel = 4'(1 << (a % 4));
    else if (v.size == 2'd1) sel = 4'(3 << (a % 4));
    else                     sel = 4'hF;
    chk({nm, "_hung"},   32'(o.hung), 32'd0);
    chk({nm, "_err"},    o.err_n, mis ? 1 : 0);
    chk({nm, "_ack"},    o.ack_n, mis ? 0 : 1);
    chk({nm, "_cyc"},    o.cyc_n, mis ? 0 : v.waits + 1);
    chk({nm, "_lat"},    o.latency, mis ? 1 : v.waits + 2);
    chk({nm, "_load"},   o.load_n, (!mis && !v.we) ? 1 : 0);
    chk({nm, "_rdat"},   o.rdat, (!mis && !v.we) ? v.rdt : 32'h0);
    chk({nm, "_leak"},   o.leak, 0);
    chk({nm, "_extra"},  o.extra, 0);
    if (!mis) begin
      chk({nm, "_wbadr"}, o.adr, a - (a % 4));
      chk({nm, "_sel"},   32'(o.sel), 32'(sel));
      chk({nm, "_wbdat"}, o.dat, v.wdat);
      chk({nm, "_we"},    32'(o.we), 32'(v.we));
      chk({nm, "_stable"}, o.unstable, 0);
    end
  endtask

  initial begin
    vec_t tbl[9];
    vec_t v;
    obs_t o;
    int   a0, a1;
    logic [31:0] b0, b1;
    int   nacks, nbus;

    tbl[0] = '{1'b0, 32'h100, 2'd2, 32'h0,        32'hDEADBEEF, 2, 1'b0, 4'hF, 32'h100};
    tbl[1] = '{1'b1, 32'h203, 2'd0, 32'hAB000000, 32'h0,        0, 1'b0, 4'h8, 32'h200};
    tbl[2] = '{1'b0, 32'h301, 2'd1, 32'h0,        32'h12345678, 0, 1'b1, 4'h0, 32'h0};
    tbl[3] = '{1'b1, 32'h402, 2'd1, 32'h55AA0000, 32'h0,        1, 1'b0, 4'hC, 32'h400};
    tbl[4] = '{1'b0, 32'h501, 2'd0, 32'h0,        32'h0000CD00, 0, 1'b0, 4'h2, 32'h500};
    tbl[5] = '{1'b1, 32'h600, 2'd3, 32'hCAFEF00D, 32'h0,        1, 1'b0, 4'hF, 32'h600};
    tbl[6] = '{1'b0, 32'h702, 2'd2, 32'h0,        32'h0,        0, 1'b1, 4'h0, 32'h0};
    tbl[7] = '{1'b1, 32'h800, 2'd1, 32'h00001234, 32'h0,        2, 1'b0, 4'h3, 32'h800};
    tbl[8] = '{1'b0, 32'h900, 2'd0, 32'h0,        32'h00000077, 3, 1'b0, 4'h1, 32'h900};

    i_rst = 1'b1; i_req = 1'b0; i_we = 1'b0; i_adr = '0; i_size = '0;
    i_wdat = '0; i_wb_rdt = '0; i_wb_ack = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_cyc",   32'(o_wb_cyc), 32'd0);
    chk("rst_ack",   32'(o_ack),    32'd0);
    chk("rst_err",   32'(o_err),    32'd0);
    chk("rst_load",  32'(o_load),   32'd0);
    chk("rst_rdat",  o_rdat,        32'h0);
    chk("rst_wbadr", o_wb_adr,      32'h0);
    chk("rst_sel",   32'(o_wb_sel), 32'd0);
    chk("rst_wbdat", o_wb_dat,      32'h0);
    chk("rst_we",    32'(o_wb_we),  32'd0);
    i_rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      txn(tbl[i], o);
      chk($sformatf("tbl%0d_err_tab", i), 32'(o.err_n), 32'(tbl[i].exp_err));
      chk($sformatf("tbl%0d_sel_tab", i), 32'(o.sel), 32'(tbl[i].exp_sel));
      chk($sformatf("tbl%0d_adr_tab", i), o.adr, tbl[i].exp_adr);
      check_txn($sformatf("tbl%0d", i), tbl[i], o);
    end

    // Back-to-back zero-wait word stores, request held through the ack.
    a0 = -1; a1 = -1; b0 = '1; b1 = '1; nacks = 0; nbus = 0;
    i_req = 1'b1; i_we = 1'b1; i_adr = 32'h0; i_size = 2'd2; i_wdat = 32'h11111111;
    for (int c = 0; c < 12; c++) begin
      i_wb_ack = o_wb_cyc;
      #3;
      if (o_wb_cyc) begin
        if (nbus == 0) b0 = o_wb_adr; else b1 = o_wb_adr;
        nbus++;
      end
      if (o_ack) begin
        if (nacks == 0) a0 = c; else a1 = c;
        nacks++;
      end
      @(posedge i_clk); #1;
      if (nacks == 1) begin i_adr = 32'h4; i_wdat = 32'h22222222; end
      if (nacks >= 2) i_req = 1'b0;
    end
    i_wb_ack = 1'b0;
    chk("b2b_nacks", nacks, 2);
    chk("b2b_gap",   a1 - a0, 3);
    chk("b2b_adr0",  b0, 32'h0);
    chk("b2b_adr1",  b1, 32'h4);

    // Reset while the bus cycle is open, then a stale ack.
    i_req = 1'b1; i_we = 1'b0; i_adr = 32'h100; i_size = 2'd2;
    @(posedge i_clk); #1;
    chk("rstbus_cyc_before", 32'(o_wb_cyc), 32'd1);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0; i_req = 1'b0; i_wb_ack = 1'b1; i_wb_rdt = 32'hFFFFFFFF;
    #3;
    chk("rstbus_cyc",   32'(o_wb_cyc), 32'd0);
    chk("rstbus_load",  32'(o_load),   32'd0);
    chk("rstbus_ack",   32'(o_ack),    32'd0);
    chk("rstbus_rdat",  o_rdat,        32'h0);
    chk("rstbus_wbadr", o_wb_adr,      32'h0);
    @(posedge i_clk); #1;
    i_wb_ack = 1'b0;
    #3;
    chk("rstbus_ack2", 32'(o_ack | o_err | o_wb_cyc), 32'd0);
    @(posedge i_clk); #1;

`ifdef SERV_DBUS_TIMEOUT_EN
    v = '{1'b0, 32'hA00, 2'd2, 32'h0, 32'h0, 1000, 1'b0, 4'hF, 32'hA00};
    txn(v, o);
    chk("to_hung",  32'(o.hung), 32'd0);
    chk("to_cyc",   o.cyc_n, TO);
    chk("to_err",   o.err_n, 1);
    chk("to_ack",   o.ack_n, 0);
    chk("to_load",  o.load_n, 0);
    chk("to_lat",   o.latency, TO + 1);
    chk("to_extra", o.extra, 0);
`else
    v = '{1'b0, 32'hA00, 2'd2, 32'h0, 32'h0BADF00D, 40, 1'b0, 4'hF, 32'hA00};
    txn(v, o);
    check_txn("longwait", v, o);
`endif

    for (int i = 0; i < 40; i++) begin
      v.we    = 1'($urandom_range(0, 1));
      v.adr   = $urandom;
      v.size  = 2'($urandom_range(0, 3));
      v.wdat  = $urandom;
      v.rdt   = $urandom;
      v.waits = $urandom_range(0, MAXW);
      txn(v, o);
      check_txn($sformatf("rnd%0d", i), v, o);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
